// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and arithmetic helpers for the convolution MAC array.
//   Word format: DATA_WIDTH-bit signed fixed point with FRAC_BITS fraction bits.
//   round_prod : full-width product -> rounded word ((p >>> FRAC_BITS) + sign bit of p)
//   sat_word   : wide signed value -> word clamped to the signed word range
package conv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 16;
  localparam int KNL_DIM    = 5;
  localparam int KNL_SIZE   = KNL_DIM * KNL_DIM;
  localparam int KNL_MAXNUM = 16;

  localparam int WFILE_SIZE = KNL_MAXNUM * KNL_SIZE;
  localparam int CHNL_W     = $clog2(KNL_MAXNUM);
  localparam int NUM_W      = CHNL_W + 1;
  localparam int WIDX_W     = $clog2(WFILE_SIZE);
  localparam int PIDX_W     = $clog2(KNL_SIZE);
  localparam int PCNT_W     = $clog2(KNL_SIZE + 1);
  // Wide enough to hold the exact sum of KNL_SIZE words plus one more word.
  localparam int SUM_W      = DATA_WIDTH + $clog2(KNL_SIZE) + 1;

  function automatic logic signed [DATA_WIDTH-1:0] round_prod(
    input logic signed [2*DATA_WIDTH-1:0] prod
  );
    return DATA_WIDTH'(prod >>> FRAC_BITS)
         + {{(DATA_WIDTH-1){1'b0}}, prod[2*DATA_WIDTH-1]};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_word(
    input logic signed [SUM_W-1:0] v
  );
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    hi = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < lo) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else             return DATA_WIDTH'(v);
  endfunction

endpackage

// File: rtl/conv_mul_round.sv
// conv_mul_round: one signed fixed-point multiply followed by rounding back to a word.
//   a, b : signed words
//   y    : round_prod(a * b), combinational
module conv_mul_round
  import conv_pkg::*;
(
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [2*DATA_WIDTH-1:0] a_ext;
  logic signed [2*DATA_WIDTH-1:0] b_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;

  assign a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign y     = round_prod(prod);

endmodule

// File: rtl/conv_mac_array.sv
// conv_mac_array: pipelined KxK convolution MAC. Per start, out_data = psum_in +
// rounded dot product of the input window with kernel chnl, three cycles later.
//   Inputs : clk, srst (sync, active high), cfg_num_knls, ld_knl_valid/ld_knl_data,
//            ld_pix_valid/ld_pix_data, start, chnl, psum_in
//   Outputs: out_valid, out_data, out_err (chnl out of range), busy, win_rdy
// Build option: CONV_SAT_EN makes the tree sum and final add saturate instead of wrap.
module conv_mac_array
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  srst,
  input  logic [NUM_W-1:0]      cfg_num_knls,
  input  logic                  ld_knl_valid,
  input  logic [DATA_WIDTH-1:0] ld_knl_data,
  input  logic                  ld_pix_valid,
  input  logic [DATA_WIDTH-1:0] ld_pix_data,
  input  logic                  start,
  input  logic [CHNL_W-1:0]     chnl,
  input  logic [DATA_WIDTH-1:0] psum_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  busy,
  output logic                  win_rdy
);

`ifdef CONV_SAT_EN
  localparam int ACC_W = SUM_W;
`else
  localparam int ACC_W = DATA_WIDTH;
`endif

  logic [DATA_WIDTH-1:0] knl_file [WFILE_SIZE];
  logic [DATA_WIDTH-1:0] win_file [KNL_SIZE];
  logic [PCNT_W-1:0]     pix_cnt;

  // Shift files: newest word lands in the top slot. Contents are never reset.
  always_ff @(posedge clk) begin
    if (ld_knl_valid) begin
      for (int i = 0; i < WFILE_SIZE-1; i++) knl_file[i] <= knl_file[i+1];
      knl_file[WFILE_SIZE-1] <= ld_knl_data;
    end
    if (ld_pix_valid) begin
      for (int i = 0; i < KNL_SIZE-1; i++) win_file[i] <= win_file[i+1];
      win_file[KNL_SIZE-1] <= ld_pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      pix_cnt <= '0;
    else if (ld_pix_valid && pix_cnt != PCNT_W'(KNL_SIZE))
      pix_cnt <= pix_cnt + 1'b1;
  end

  assign win_rdy = (pix_cnt == PCNT_W'(KNL_SIZE));

  // Kernel slot = KNL_MAXNUM - cfg_num_knls + chnl, taken mod KNL_MAXNUM so the
  // index stays in range even for an erroring chnl (its result is discarded).
  logic                         s0_err;
  logic [CHNL_W-1:0]            kslot;
  logic [WIDX_W-1:0]            kbase;
  logic signed [DATA_WIDTH-1:0] term [KNL_SIZE];

  assign s0_err = ({1'b0, chnl} >= cfg_num_knls);
  assign kslot  = CHNL_W'(KNL_MAXNUM) - cfg_num_knls[CHNL_W-1:0] + chnl;
  assign kbase  = WIDX_W'(kslot) * WIDX_W'(KNL_SIZE);

  // Weights are row-major, the window is column-major: weight[r*K+c] * window[c*K+r].
  for (genvar i = 0; i < KNL_SIZE; i++) begin : g_mul
    localparam int ROW = i / KNL_DIM;
    localparam int COL = i % KNL_DIM;
    conv_mul_round u_mul (
      .a (knl_file[kbase + WIDX_W'(i)]),
      .b (win_file[PIDX_W'(COL*KNL_DIM + ROW)]),
      .y (term[i])
    );
  end

  logic                         s1_valid, s2_valid;
  logic                         s1_err, s2_err;
  logic signed [DATA_WIDTH-1:0] s1_psum, s2_psum;
  logic signed [DATA_WIDTH-1:0] s1_term [KNL_SIZE];
  logic signed [DATA_WIDTH-1:0] s2_sum;
  logic signed [ACC_W-1:0]      tree_acc;
  logic signed [DATA_WIDTH-1:0] s2_sum_nxt;
  logic signed [DATA_WIDTH-1:0] out_nxt;

  always_comb begin
    tree_acc = '0;
    for (int i = 0; i < KNL_SIZE; i++) tree_acc = tree_acc + ACC_W'(s1_term[i]);
`ifdef CONV_SAT_EN
    s2_sum_nxt = sat_word(tree_acc);
`else
    s2_sum_nxt = tree_acc;
`endif
  end

  always_comb begin
`ifdef CONV_SAT_EN
    out_nxt = sat_word(ACC_W'(s2_psum) + ACC_W'(s2_sum));
`else
    out_nxt = s2_psum + s2_sum;
`endif
    if (s2_err) out_nxt = s2_psum;
  end

  // Control path: reset flushes every stage, and a start coinciding with srst is dropped.
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_valid  <= start;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_err  <= s2_err;
        out_data <= out_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      s1_err  <= s0_err;
      s1_psum <= psum_in;
      for (int i = 0; i < KNL_SIZE; i++) s1_term[i] <= term[i];
    end
    if (s1_valid) begin
      s2_err  <= s1_err;
      s2_psum <= s1_psum;
      s2_sum  <= s2_sum_nxt;
    end
  end

  assign busy = s1_valid | s2_valid | out_valid;

endmodule

// File: tb/tb_conv_mac_array.sv
module tb_conv_mac_array;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [4:0]  cfg_num_knls = 5'd16;
  logic        ld_knl_valid = 1'b0;
  logic [31:0] ld_knl_data = '0;
  logic        ld_pix_valid = 1'b0;
  logic [31:0] ld_pix_data = '0;
  logic        start = 1'b0;
  logic [3:0]  chnl = '0;
  logic [31:0] psum_in = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_err;
  logic        busy;
  logic        win_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_mac_array dut (
    .clk          (clk),
    .srst         (srst),
    .cfg_num_knls (cfg_num_knls),
    .ld_knl_valid (ld_knl_valid),
    .ld_knl_data  (ld_knl_data),
    .ld_pix_valid (ld_pix_valid),
    .ld_pix_data  (ld_pix_data),
    .start        (start),
    .chnl         (chnl),
    .psum_in      (psum_in),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_err      (out_err),
    .busy         (busy),
    .win_rdy      (win_rdy)
  );

  task automatic load_knl(input logic [31:0] w, input int n);
    repeat (n) begin
      @(negedge clk);
      ld_knl_valid = 1'b1;
      ld_knl_data  = w;
    end
    @(negedge clk);
    ld_knl_valid = 1'b0;
  endtask

  task automatic load_pix(input logic [31:0] p, input int n);
    repeat (n) begin
      @(negedge clk);
      ld_pix_valid = 1'b1;
      ld_pix_data  = p;
    end
    @(negedge clk);
    ld_pix_valid = 1'b0;
  endtask

  // Pulse start for one cycle, then wait (bounded) for out_valid; lat counts negedges.
  task automatic run_start(input logic [3:0] ch, input logic [31:0] ps, output int lat);
    @(negedge clk);
    start   = 1'b1;
    chnl    = ch;
    psum_in = ps;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int seen;
    srst  = 1'b1;
    start = 1'b1;
    chnl  = 4'd0;
    repeat (2) @(negedge clk);
    srst  = 1'b0;
    start = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got %08h want 00000000", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %0b want 0", out_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (win_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_win_rdy got %0b want 0", win_rdy); end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL reset_start_dropped got %0d strobes want 0", seen); end
  endtask

  task automatic test_win_rdy();
    load_pix(32'h0002_0000, 24);
    n_cmp++; if (win_rdy !== 1'b0) begin n_bad++; $display("FAIL win_rdy_24 got %0b want 0", win_rdy); end
    load_pix(32'h0002_0000, 1);
    n_cmp++; if (win_rdy !== 1'b1) begin n_bad++; $display("FAIL win_rdy_25 got %0b want 1", win_rdy); end
    load_pix(32'h0002_0000, 3);
    n_cmp++; if (win_rdy !== 1'b1) begin n_bad++; $display("FAIL win_rdy_sat got %0b want 1", win_rdy); end
  endtask

  task automatic test_basic();
    int lat;
    cfg_num_knls = 5'd16;
    load_knl(32'h0001_0000, 400);
    load_pix(32'h0002_0000, 25);
    run_start(4'd0, 32'h0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL basic_latency got %0d want 3", lat); end
    n_cmp++; if (out_data !== 32'h0032_0000) begin n_bad++; $display("FAIL basic_data got %08h want 00320000", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %0b want 0", out_err); end
    run_start(4'd15, 32'h0001_0000, lat);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0033_0000) begin n_bad++; $display("FAIL basic_psum got v=%0b %08h want v=1 00330000", out_valid, out_data); end
  endtask

  task automatic test_rounding();
    int lat;
    cfg_num_knls = 5'd1;
    load_knl(32'hFFFF_8000, 1);
    load_knl(32'h0, 24);
    load_pix(32'h0001_0000, 1);
    load_pix(32'h0, 24);
    run_start(4'd0, 32'h0, lat);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_8001) begin n_bad++; $display("FAIL rounding got v=%0b %08h want v=1 ffff8001", out_valid, out_data); end
  endtask

  task automatic test_back_to_back();
    cfg_num_knls = 5'd3;
    load_knl(32'h0001_0000, 25);
    load_knl(32'h0002_0000, 25);
    load_knl(32'h0003_0000, 25);
    load_pix(32'h0001_0000, 25);
    @(negedge clk);
    start = 1'b1; chnl = 4'd0; psum_in = 32'h0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy1 got %0b want 1", busy); end
    chnl = 4'd1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy2 got %0b want 1", busy); end
    chnl = 4'd2;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0019_0000 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_out0 got v=%0b %08h busy=%0b want v=1 00190000 busy=1", out_valid, out_data, busy); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0032_0000 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_out1 got v=%0b %08h busy=%0b want v=1 00320000 busy=1", out_valid, out_data, busy); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h004B_0000 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_out2 got v=%0b %08h busy=%0b want v=1 004b0000 busy=1", out_valid, out_data, busy); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got v=%0b busy=%0b want v=0 busy=0", out_valid, busy); end
  endtask

  task automatic test_error();
    int lat;
    cfg_num_knls = 5'd4;
    run_start(4'd5, 32'h0000_1234, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL err_latency got %0d want 3", lat); end
    n_cmp++; if (out_err !== 1'b1 || out_data !== 32'h0000_1234) begin n_bad++; $display("FAIL err_chnl5 got err=%0b %08h want err=1 00001234", out_err, out_data); end
    run_start(4'd4, 32'h0000_0055, lat);
    n_cmp++; if (out_err !== 1'b1 || out_data !== 32'h0000_0055) begin n_bad++; $display("FAIL err_chnl4 got err=%0b %08h want err=1 00000055", out_err, out_data); end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] exp_data;
`ifdef CONV_SAT_EN
    exp_data = 32'h7FFF_FFFF;
`else
    exp_data = 32'h8001_0000;
`endif
    cfg_num_knls = 5'd1;
    load_knl(32'h0001_0000, 1);
    load_knl(32'h0, 24);
    load_pix(32'h0002_0000, 1);
    load_pix(32'h0, 24);
    run_start(4'd0, 32'h7FFF_0000, lat);
    n_cmp++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== exp_data) begin n_bad++; $display("FAIL overflow got v=%0b err=%0b %08h want v=1 err=0 %08h", out_valid, out_err, out_data, exp_data); end
  endtask

  task automatic test_mid_reset();
    int seen;
    @(negedge clk);
    start = 1'b1; chnl = 4'd0; psum_in = 32'h0;
    @(negedge clk);
    start = 1'b0;
    srst  = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %0b want 0", busy); end
    n_cmp++; if (win_rdy !== 1'b0) begin n_bad++; $display("FAIL midrst_win_rdy got %0b want 0", win_rdy); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_flush got %0d strobes want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_win_rdy();
    test_basic();
    test_rounding();
    test_back_to_back();
    test_error();
    test_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
